// File: rtl/uart_tx_6502.sv
// Memory-mapped 8N1 UART transmitter for the 6502 bus: an 8-entry TX FIFO feeds
// a start/data/stop serializer; STATUS, CTRL and a 16-bit baud divisor are bus visible.
module uart_tx_6502 #(
  parameter int          FIFO_AW        = 3,
  parameter logic [15:0] BAUD_DIV_RESET = 16'd107
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       cs,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       we,
  output logic       tx,
  output logic       irq
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q;
  logic [1:0]         ctrl_q;
  logic [15:0]        div_q;
  state_e             state_q, state_d;
  logic [15:0]        timer_q, timer_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               irq_q;

  logic bus_wr, push_req, push_ok, ovf_set, pop;
  logic full, empty, busy, tx_en, irq_en, timer_done, can_start;

  assign bus_wr     = cs & we;
  assign full       = (count_q == CNT_FULL);
  assign empty      = (count_q == '0);
  assign busy       = (state_q != IDLE);
  assign tx_en      = ctrl_q[0];
  assign irq_en     = ctrl_q[1];
  assign push_req   = bus_wr && (addr == 3'd0);
  // A push into a full FIFO is dropped even if the serializer pops on the same edge.
  assign push_ok    = push_req && !full;
  assign ovf_set    = push_req && full;
  assign timer_done = (timer_q == 16'd0);
  assign can_start  = tx_en && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (can_start) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
          timer_d = div_q;
        end
      end
      START: begin
        if (timer_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          timer_d   = div_q;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        if (timer_done) begin
          timer_d = div_q;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      STOP: begin
        if (timer_done) begin
          // Chain straight into the next start bit so queued bytes go out gap-free.
          if (can_start) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            state_d = START;
            tx_d    = 1'b0;
            timer_d = div_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ctrl_q     <= 2'b00;
      div_q      <= BAUD_DIV_RESET;
      state_q    <= IDLE;
      timer_q    <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      if (ovf_set)                                   overflow_q <= 1'b1;
      else if (bus_wr && addr == 3'd1 && din[3])     overflow_q <= 1'b0;
      if (bus_wr && addr == 3'd2) ctrl_q       <= din[1:0];
      if (bus_wr && addr == 3'd3) div_q[7:0]   <= din;
      if (bus_wr && addr == 3'd4) div_q[15:8]  <= din;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      irq_q     <= irq_en && empty && !busy;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= din;
  end

  always_comb begin
    dout = 8'h00;
    case (addr)
      3'd1:    dout = {4'b0000, overflow_q, busy, empty, full};
      3'd2:    dout = {6'b000000, ctrl_q};
      3'd3:    dout = div_q[7:0];
      3'd4:    dout = div_q[15:8];
      default: dout = 8'h00;
    endcase
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_tx_6502.sv
// Bench for uart_tx_6502: bus driver tasks push expected bytes into a queue; a tx-line
// monitor decodes 8N1 frames at the known bit period and checks them against the queue.
module tb_uart_tx_6502;

  logic       clk = 1'b0;
  logic       reset_;
  logic       cs, we, tx, irq;
  logic [2:0] addr;
  logic [7:0] din, dout;

  uart_tx_6502 dut (
    .clk(clk), .reset_(reset_), .cs(cs), .addr(addr), .din(din),
    .dout(dout), .we(we), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         frame_starts[$];
  int         cyc = 0;
  int         bit_p = 108;
  bit         mon_en = 1'b0;
  bit         mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(posedge clk);
    #1 cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    #1 d = dout;
    cs = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input int exp);
    logic [7:0] d;
    bus_read(a, d);
    check(name, int'(d), exp);
  endtask

  task automatic set_div(input int d);
    bit_p = d + 1;
    bus_write(3'd3, d[7:0]);
    bus_write(3'd4, d[15:8]);
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || mon_busy) && g < 20000) begin
      @(negedge clk);
      g++;
    end
    check(name, int'(g < 20000), 1);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: a frame is 10 bits of bit_p clocks each; every sample in a bit must agree.
  int         mon_p;
  logic [7:0] mon_data;
  bit         mon_ok;
  logic       mon_bit;
  always begin
    @(negedge clk);
    if (mon_en && reset_ && tx == 1'b0) begin
      mon_busy = 1'b1;
      frame_starts.push_back(cyc);
      mon_p  = bit_p;
      mon_ok = 1'b1;
      mon_data = 8'h00;
      for (int b = 0; b < 10; b++) begin
        for (int s = 0; s < mon_p; s++) begin
          if (!(b == 0 && s == 0)) @(negedge clk);
          if (s == 0) mon_bit = tx;
          else if (tx !== mon_bit) mon_ok = 1'b0;
        end
        if (b == 0 && mon_bit !== 1'b0) mon_ok = 1'b0;
        if (b >= 1 && b <= 8) mon_data[b-1] = mon_bit;
        if (b == 9 && mon_bit !== 1'b1) mon_ok = 1'b0;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_frame", int'(mon_data), -1);
      end else begin
        check("frame_data", int'(mon_data), int'(exp_q.pop_front()));
        check("frame_shape", int'(mon_ok), 1);
      end
      mon_busy = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rst_exp [8];
    logic [7:0] b;
    int         n, g, d, lows;
    logic       samp [96];
    int         runs[$];
    int         run_exp [9];

    rst_exp = '{8'h00, 8'h02, 8'h00, 8'h6B, 8'h00, 8'h00, 8'h00, 8'h00};
    run_exp = '{4, 4, 4, 4, 8, 8, 8, 8, 8};
    reset_ = 1'b0; cs = 1'b0; we = 1'b0; addr = 3'd0; din = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_ = 1'b1;

    // Reset register image and idle outputs
    for (int i = 0; i < 8; i++) read_check($sformatf("reset_reg%0d", i), 3'(i), int'(rst_exp[i]));
    check("reset_tx", int'(tx), 1);
    check("reset_irq", int'(irq), 0);
    mon_en = 1'b1;

    // Single A5 frame: one clock latency, 40-clock busy window
    set_div(3);
    bus_write(3'd2, 8'h01);
    exp_q.push_back(8'hA5);
    bus_write(3'd0, 8'hA5);
    addr = 3'd1;
    @(negedge clk);
    check("lat_tx_still_high", int'(tx), 1);
    @(negedge clk);
    check("lat_tx_low", int'(tx), 0);
    n = 0; g = 0;
    while (dout[2] === 1'b1 && g < 500) begin n++; g++; @(negedge clk); end
    check("busy_len", n, 40);
    wait_drain("drain_a5");
    read_check("a5_status_after", 3'd1, 8'h02);

    // Fill past full with tx disabled, clear overflow, then burst out back-to-back
    d = $urandom_range(0, 3);
    set_div(d);
    bus_write(3'd2, 8'h00);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 8) exp_q.push_back(b);
      bus_write(3'd0, b);
    end
    read_check("full_ovf_status", 3'd1, 8'h09);
    bus_write(3'd1, 8'h08);
    read_check("ovf_cleared_status", 3'd1, 8'h01);
    frame_starts.delete();
    bus_write(3'd2, 8'h01);
    wait_drain("drain_burst");
    check("burst_frames", frame_starts.size(), 8);
    for (int i = 1; i < frame_starts.size(); i++)
      check($sformatf("burst_gap%0d", i), frame_starts[i] - frame_starts[i-1], 10 * bit_p);
    read_check("burst_status_after", 3'd1, 8'h02);

    // Random bursts at random small divisors with tx enabled
    for (int r = 0; r < 3; r++) begin
      set_div($urandom_range(0, 2));
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        bus_write(3'd0, b);
      end
      wait_drain($sformatf("drain_rand%0d", r));
      read_check($sformatf("rand_status%0d", r), 3'd1, 8'h02);
    end

    // irq follows idle & empty with one clock of register delay
    set_div(1);
    bus_write(3'd2, 8'h03);
    repeat (2) @(negedge clk);
    check("irq_idle", int'(irq), 1);
    exp_q.push_back(8'h3C);
    bus_write(3'd0, 8'h3C);
    @(negedge clk);
    @(negedge clk);
    check("irq_drop", int'(irq), 0);
    n = 0;
    while (irq !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    check("irq_reassert", n, 10 * bit_p + 1);
    wait_drain("drain_irq");
    bus_write(3'd2, 8'h00);

    // Clearing tx_en mid-frame finishes the frame and leaves two bytes queued
    set_div(3);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      bus_write(3'd0, b);
    end
    read_check("three_queued_status", 3'd1, 8'h00);
    bus_write(3'd2, 8'h01);
    repeat (12) @(negedge clk);
    bus_write(3'd2, 8'h00);
    g = 0;
    while ((exp_q.size() != 2 || mon_busy) && g < 2000) begin @(negedge clk); g++; end
    check("txen_frame_done", int'(g < 2000), 1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    check("txen_off_tx_idle", lows, 0);
    read_check("txen_off_status", 3'd1, 8'h00);
    bus_write(3'd2, 8'h01);
    wait_drain("drain_remaining");
    read_check("remaining_status", 3'd1, 8'h02);

    // Reset mid-frame aborts immediately
    mon_en = 1'b0;
    bus_write(3'd0, 8'hF0);
    repeat (10) @(negedge clk);
    reset_ = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_tx", int'(tx), 1);
    addr = 3'd1;
    #1 check("midreset_status", int'(dout), 8'h02);
    addr = 3'd3;
    #1 check("midreset_div", int'(dout), 8'h6B);
    @(negedge clk) reset_ = 1'b1;

    // Divisor 3 -> 7 written during data bit 2
    set_div(3);
    bus_write(3'd2, 8'h01);
    bus_write(3'd0, 8'h55);
    g = 0;
    while (tx !== 1'b0 && g < 100) begin @(negedge clk); g++; end
    check("divchg_start_seen", int'(g < 100), 1);
    for (int k = 0; k < 96; k++) begin
      if (k > 0) @(negedge clk);
      samp[k] = tx;
      if (k == 13) begin cs = 1'b1; we = 1'b1; addr = 3'd3; din = 8'h07; end
      if (k == 14) begin cs = 1'b0; we = 1'b0; end
    end
    n = 1;
    for (int k = 1; k < 96; k++) begin
      if (samp[k] === samp[k-1]) n++;
      else begin runs.push_back(n); n = 1; end
    end
    check("divchg_run_count", int'(runs.size() >= 9), 1);
    for (int i = 0; i < 9 && i < runs.size(); i++)
      check($sformatf("divchg_run%0d", i), runs[i], run_exp[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
